sobel_filter: RTL and testbench

- Sobel gradient stage of the edge-detect pipeline.
- Sits between the grayscale FIFO (upstream) and the sobel output FIFO (downstream) inside edge_detect_top.
- Pops one 8-bit gray pixel per cycle in raster order and pushes one 8-bit edge-magnitude pixel per input pixel.
- Holds a sliding 3x3 window over two buffered image rows.

---
 rtl/sobel_filter.sv | 130 +++++++++++++
 tb/tb_sobel_filter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sobel_filter.sv
// rtl/sobel_filter.sv - 3x3 Sobel gradient magnitude over a raster pixel stream
// Pixel k leaves paired with the pop of pixel k+WIDTH+1; the final WIDTH+1 border outputs drain in FLUSH.
module sobel_filter #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       in_re,
  input  logic       out_full,
  output logic       out_we,
  output logic [7:0] out_din
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = $clog2(NPIX);
  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);
  localparam int TAPS = 2 * WIDTH + 2;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   pix_cnt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [7:0]      sr [TAPS];
  logic            last_out;
  logic            border;
  logic [7:0]      sat;

  // sr[0] is the newest stored pixel; in_dout supplies the bottom-right tap
  logic [7:0] p_tl, p_tm, p_tr, p_ml, p_mr, p_bl, p_bm, p_br;
  logic [9:0] sx_p, sx_n, sy_p, sy_n;
  logic signed [10:0] gx, gy;
  logic [9:0]  ax, ay;
  logic [11:0] sum12, mag;

  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  always_comb begin
    p_br = in_dout;
    p_bm = sr[0];
    p_bl = sr[1];
    p_mr = sr[WIDTH-1];
    p_ml = sr[WIDTH+1];
    p_tr = sr[2*WIDTH-1];
    p_tm = sr[2*WIDTH];
    p_tl = sr[2*WIDTH+1];
    sx_p = wsum(p_tr, p_mr, p_br);
    sx_n = wsum(p_tl, p_ml, p_bl);
    sy_p = wsum(p_bl, p_bm, p_br);
    sy_n = wsum(p_tl, p_tm, p_tr);
    gx = $signed({1'b0, sx_p}) - $signed({1'b0, sx_n});
    gy = $signed({1'b0, sy_p}) - $signed({1'b0, sy_n});
    ax = gx[10] ? 10'(-gx) : 10'(gx);
    ay = gy[10] ? 10'(-gy) : 10'(gy);
    sum12 = {2'b00, ax} + {2'b00, ay};
    mag = sum12 >> 1;
    sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
  end

  assign last_out = (row == RW'(HEIGHT-1)) && (col == CW'(WIDTH-1));
  assign border   = (row == '0) || (row == RW'(HEIGHT-1)) || (col == '0) || (col == CW'(WIDTH-1));

  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (in_re && pix_cnt == PW'(WIDTH))  state_nx = RUN;
      RUN:     if (in_re && pix_cnt == PW'(NPIX-1)) state_nx = FLUSH;
      FLUSH:   if (out_we && last_out)              state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_comb begin
    in_re   = 1'b0;
    out_we  = 1'b0;
    out_din = 8'h00;
    if (!reset) begin
      case (state)
        FILL: in_re = !in_empty;
        RUN: begin
          in_re   = !in_empty && !out_full;
          out_we  = !in_empty && !out_full;
          out_din = border ? 8'h00 : sat;
        end
        FLUSH: out_we = !out_full;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (state == FLUSH && out_we && last_out)) begin
      pix_cnt <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      if (in_re) pix_cnt <= pix_cnt + 1'b1;
      if (out_we) begin
        if (col == CW'(WIDTH-1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) sr[i] <= 8'h00;
    end else if (in_re) begin
      for (int i = TAPS-1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= in_dout;
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// tb/tb_sobel_filter.sv - directed checks of sobel_filter on an 8x6 image
module tb_sobel_filter;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_empty;
  logic [7:0] in_dout;
  logic       in_re;
  logic       out_full;
  logic       out_we;
  logic [7:0] out_din;

  sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout), .in_re(in_re),
    .out_full(out_full), .out_we(out_we), .out_din(out_din)
  );

  always #5 clock = ~clock;

  logic [7:0] feed_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] ref_q[$];
  int feed_idx, pops, full_left, stall_cycles, stall_bad, early_bad;
  int total = 0;
  int bad = 0;
  bit plan, t_run, t_fl;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] in_px(input int pat, input int r, input int c);
    if (pat == 1) return 8'd100;
    if (pat == 2) return (c < 4) ? 8'd0 : 8'd200;
    return 8'(10 * c);
  endfunction

  function automatic logic [7:0] exp_px(input int pat, input int r, input int c);
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'd0;
    if (pat == 1) return 8'd0;
    if (pat == 2) return (c == 3 || c == 4) ? 8'd255 : 8'd0;
    return 8'd40;
  endfunction

  task automatic load_frame(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        feed_q.push_back(in_px(pat, r, c));
  endtask

  task automatic clear_all();
    feed_q.delete();
    cap_q.delete();
    feed_idx = 0; pops = 0; full_left = 0; stall_cycles = 0; stall_bad = 0; early_bad = 0;
    plan = 0; t_run = 0; t_fl = 0;
  endtask

  task automatic step(input bit rnd);
    @(negedge clock);
    if (plan && !t_run && feed_idx == 20) begin full_left = 5; t_run = 1; end
    if (plan && !t_fl && cap_q.size() == 42) begin full_left = 3; t_fl = 1; end
    in_empty = (feed_idx >= feed_q.size()) || (rnd && $urandom_range(0, 9) < 3);
    in_dout  = (feed_idx < feed_q.size()) ? feed_q[feed_idx] : 8'h00;
    out_full = (full_left > 0);
    #1;
    if (out_full) begin
      stall_cycles++;
      if (in_re || out_we) stall_bad++;
    end
    if (in_empty && in_re) stall_bad++;
    if (out_we && pops < W + 1) early_bad++;
    if (in_re) begin feed_idx++; pops++; end
    if (out_we) cap_q.push_back(out_din);
    if (full_left > 0) full_left--;
  endtask

  task automatic run_until(input string tag, input int n, input bit rnd);
    int cyc = 0;
    while (cap_q.size() < n && cyc < 3000) begin
      step(rnd);
      cyc++;
    end
    repeat (6) step(1'b0);
    chk(tag, 16'(cap_q.size()), 16'(n));
  endtask

  task automatic check_frame(input string tag, input int pat, input int off);
    for (int k = 0; k < N; k++)
      chk(tag, 16'(cap_q[off + k]), 16'(exp_px(pat, k / W, k % W)));
  endtask

  initial begin
    reset = 1'b1; in_empty = 1'b0; in_dout = 8'h00; out_full = 1'b0;
    clear_all();
    repeat (3) @(negedge clock);
    #1;
    chk("rst_in_re", 16'(in_re), 16'd0);
    chk("rst_out_we", 16'(out_we), 16'd0);
    @(negedge clock);
    reset = 1'b0; in_empty = 1'b1;
    #1;
    chk("idle_in_re", 16'(in_re), 16'd0);
    chk("idle_out_we", 16'(out_we), 16'd0);

    // flat frame
    clear_all(); load_frame(1);
    run_until("t1_count", N, 1'b0);
    check_frame("t1_px", 1, 0);
    chk("t1_early_we", 16'(early_bad), 16'd0);
    chk("t1_flow", 16'(stall_bad), 16'd0);

    // vertical step edge
    clear_all(); load_frame(2);
    run_until("t2_count", N, 1'b0);
    check_frame("t2_px", 2, 0);

    // horizontal ramp
    clear_all(); load_frame(3);
    run_until("t3_count", N, 1'b0);
    check_frame("t3_px", 3, 0);
    ref_q = cap_q;

    // ramp with downstream back-pressure in RUN and in FLUSH
    clear_all(); load_frame(3); plan = 1;
    run_until("t4_count", N, 1'b0);
    chk("t4_stall_cycles", 16'(stall_cycles), 16'd8);
    chk("t4_stall_flow", 16'(stall_bad), 16'd0);
    for (int k = 0; k < N; k++) chk("t4_vs_t3", 16'(cap_q[k]), 16'(ref_q[k]));

    // ragged upstream, two frames back-to-back
    clear_all(); load_frame(2); load_frame(3);
    run_until("t5_count", 2 * N, 1'b1);
    chk("t5_flow", 16'(stall_bad), 16'd0);
    check_frame("t5_px_a", 2, 0);
    check_frame("t5_px_b", 3, N);

    // reset mid-frame, then a fresh flat frame
    clear_all(); load_frame(3);
    repeat (20) step(1'b0);
    @(negedge clock);
    reset = 1'b1; in_empty = 1'b0;
    #1;
    chk("mid_rst_in_re", 16'(in_re), 16'd0);
    chk("mid_rst_out_we", 16'(out_we), 16'd0);
    @(negedge clock);
    reset = 1'b0; in_empty = 1'b1;
    clear_all(); load_frame(1);
    run_until("t6_count", N, 1'b0);
    check_frame("t6_px", 1, 0);
    chk("t6_early_we", 16'(early_bad), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
